mgt_01_fmul_normalize_round: RTL and testbench
==============================================

// Module: mgt_01_fmul_normalize_round
// PURPOSE
//  Post-multiply stage of the low-performance FP32 multiply path.
//  Consumes the 2*XLEN-bit significand product from the radix-4 Booth multiplier.
//  Normalises it, rounds per RISC-V frm, and packs an IEEE-754 single result with fflags.
//  Results are handed to the FP writeback through a valid/ready handshake.
// PARAMETERS
//  XLEN   32  operand width of the Booth multiplier; the product is 2*XLEN bits wide
//  EXP_W  10  width of the signed biased exponent sum (exp_a + exp_b - 127)
// PORTS
//  clk_i        in   1        clock
//  rst_n_i      in   1        synchronous reset, active low
//  clk_en_i     in   1        clock enable; low freezes every register and the FSM
//  product_i    in   2*XLEN   Booth product; significands 1.23 with hidden bit, so bits[47:0] are used
//  valid_i      in   1        product_i and the side-band inputs are valid (multiplier valid_o)
//  sign_i       in   1        result sign (sign_a ^ sign_b)
//  exp_sum_i    in   EXP_W    signed biased exponent sum
//  zero_i       in   1        an operand is zero; forces a signed-zero result
//  rm_i         in   3        rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM
//  ready_i      in   1        downstream accepts the result
//  busy_o       out  1        FSM not in IDLE
//  valid_o      out  1        result_o and fflags_o are valid
//  result_o     out  32       packed FP32 result
//  fflags_o     out  5        {NV,DZ,OF,UF,NX}; NV and DZ are always 0
// BEHAVIOUR
//  Operation and reset
//  - Synchronous active-low reset: FSM to IDLE; valid_o, busy_o, result_o and fflags_o are 0.
//  - Reset wins over clk_en_i. Reset mid-operation drops the operation; nothing is reported.
//  - All state advances only on edges where clk_en_i=1.
//  FSM: IDLE -> NORMALIZE -> ROUND -> DONE -> IDLE
//  - IDLE: on valid_i, capture product_i[47:0], sign_i, exp_sum_i, zero_i and rm_i, then go to NORMALIZE.
//  - valid_i in any other state is ignored; no queueing.
//  - NORMALIZE (product[47]=1): mant=p[46:24], G=p[23], S=|p[22:0], exp=exp_sum+1.
//  - NORMALIZE (product[47]=0): mant=p[45:23], G=p[22], S=|p[21:0], exp=exp_sum.
//  - ROUND, increment rule:
//      RNE: G & (S | mant[0])
//      RTZ: 0
//      RDN: sign & (G|S)
//      RUP: ~sign & (G|S)
//      RMM: G
//  - ROUND, mantissa carry-out: mant=0 and exp+1.
//  - ROUND, inexact: NX=G|S.
//  - Overflow (final exp >= 255): OF=1, NX=1.
//      Result is +/-inf for RNE, RMM, RUP(+) and RDN(-).
//      Otherwise the result is +/-0x7F7FFFFF (max finite).
//  - Underflow (final exp <= 0): flush to signed zero with UF=1, NX=1. No subnormals are produced.
//  - zero_i=1: result is {sign,31'b0} and fflags are 0, regardless of product and exponent.
//  - Exponent arithmetic is EXP_W-bit signed; inputs never exceed +/-511.
//  - DONE: valid_o=1. result_o and fflags_o are held stable until an edge with ready_i=1.
//      That edge moves the FSM to IDLE and valid_o falls the next cycle.
//  - Latency: 3 enabled edges from capture to valid_o. Minimum initiation interval is 4 cycles.
//  - ready_i is ignored outside DONE.
//  - valid_i on the same edge that DONE is left is NOT captured; the block enters IDLE first.
// TESTING
//  1. product=0x900000000000 (1.5*1.5), exp_sum=127, RNE -> result 0x40100000, fflags 0.
//  2. product=0x400000000000, exp_sum=127, sign=1 -> result 0xBF800000, fflags 0.
//  3. product=0x400000C00000, exp_sum=127 (tie, odd lsb):
//     RNE -> 0x3F800002, NX; RTZ -> 0x3F800001, NX.
//  4. product=0x800000000000, exp_sum=254:
//     RNE -> 0x7F800000, OF|NX; RTZ -> 0x7F7FFFFF, OF|NX.
//  5. product=0x400000000000, exp_sum=0, sign=1 -> 0x80000000, UF|NX.
//     Same inputs with zero_i=1 -> 0x80000000, fflags 0.
//  6. Handshake and reset:
//     - ready_i low 5 cycles in DONE: valid_o and result stay held; valid_i pulses are ignored.
//     - clk_en_i low stalls all state.
//     - rst_n_i low during ROUND: next cycle IDLE, valid_o=0, no result emitted.

Source files
------------

// File: rtl/mgt_01_fmul_normalize_round.sv
// mgt_01_fmul_normalize_round
//   Post-multiply stage of the FP32 multiply path. Captures the Booth
//   significand product and side-band data, normalises it, rounds per
//   RISC-V frm, and packs an IEEE-754 single result with fflags.
//   Results leave through a valid/ready handshake.
// Ports
//   clk_i      clock
//   rst_n_i    synchronous reset, active low
//   clk_en_i   clock enable; low freezes all state
//   product_i  Booth product, bits [47:0] used (1.23 x 1.23)
//   valid_i    product and side-band inputs valid
//   sign_i     result sign
//   exp_sum_i  signed biased exponent sum
//   zero_i     an operand is zero; forces a signed-zero result
//   rm_i       rounding mode (RNE, RTZ, RDN, RUP, RMM)
//   ready_i    downstream accepts the result
//   busy_o     FSM not idle
//   valid_o    result_o / fflags_o valid
//   result_o   packed FP32 result
//   fflags_o   {NV,DZ,OF,UF,NX}
module mgt_01_fmul_normalize_round #(
   parameter int XLEN  = 32,
   parameter int EXP_W = 10
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                clk_en_i,
   input  logic [2*XLEN-1:0]   product_i,
   input  logic                valid_i,
   input  logic                sign_i,
   input  logic [EXP_W-1:0]    exp_sum_i,
   input  logic                zero_i,
   input  logic [2:0]          rm_i,
   input  logic                ready_i,
   output logic                busy_o,
   output logic                valid_o,
   output logic [31:0]         result_o,
   output logic [4:0]          fflags_o
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_NORM  = 2'd1;
   localparam logic [1:0] ST_ROUND = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [2:0] RM_RNE = 3'b000;
   localparam logic [2:0] RM_RTZ = 3'b001;
   localparam logic [2:0] RM_RDN = 3'b010;
   localparam logic [2:0] RM_RUP = 3'b011;
   localparam logic [2:0] RM_RMM = 3'b100;

   // One guard bit of headroom so exp_sum + normalise + carry never wraps.
   localparam logic signed [EXP_W:0] EXP_ONE = (EXP_W+1)'(1);
   localparam logic signed [EXP_W:0] EXP_MAX = (EXP_W+1)'(255);
   localparam logic signed [EXP_W:0] EXP_MIN = '0;

   logic [1:0]              state_q, state_d;
   logic [47:0]             prod_q;
   logic                    sign_q;
   logic [EXP_W-1:0]        exp_in_q;
   logic                    zero_q;
   logic [2:0]              rm_q;
   logic [22:0]             mant_q, mant_d;
   logic                    g_q, g_d;
   logic                    s_q, s_d;
   logic signed [EXP_W:0]   exp_q, exp_d;
   logic [31:0]             result_q, result_d;
   logic [4:0]              fflags_q, fflags_d;

   logic                    inc;
   logic [23:0]             mant_inc;
   logic signed [EXP_W:0]   exp_r;
   logic                    to_inf;

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (valid_i) state_d = ST_NORM;
         ST_NORM:  state_d = ST_ROUND;
         ST_ROUND: state_d = ST_DONE;
         ST_DONE:  if (ready_i) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Normalise: the product of two 1.x significands lies in [1,4)
   always_comb begin
      if (prod_q[47]) begin
         mant_d = prod_q[46:24];
         g_d    = prod_q[23];
         s_d    = |prod_q[22:0];
         exp_d  = $signed({exp_in_q[EXP_W-1], exp_in_q}) + EXP_ONE;
      end else begin
         mant_d = prod_q[45:23];
         g_d    = prod_q[22];
         s_d    = |prod_q[21:0];
         exp_d  = $signed({exp_in_q[EXP_W-1], exp_in_q});
      end
   end

   // Round, then classify overflow / underflow on the post-rounding exponent
   always_comb begin
      case (rm_q)
         RM_RNE:  inc = g_q & (s_q | mant_q[0]);
         RM_RTZ:  inc = 1'b0;
         RM_RDN:  inc = sign_q & (g_q | s_q);
         RM_RUP:  inc = ~sign_q & (g_q | s_q);
         RM_RMM:  inc = g_q;
         default: inc = 1'b0;
      endcase
      mant_inc = {1'b0, mant_q} + {23'b0, inc};
      exp_r    = mant_inc[23] ? exp_q + EXP_ONE : exp_q;
      to_inf   = (rm_q == RM_RNE) | (rm_q == RM_RMM) |
                 ((rm_q == RM_RUP) & ~sign_q) | ((rm_q == RM_RDN) & sign_q);

      result_d = {sign_q, exp_r[7:0], mant_inc[22:0]};
      fflags_d = {4'b0000, g_q | s_q};
      if (zero_q) begin
         result_d = {sign_q, 31'b0};
         fflags_d = '0;
      end else if (exp_r >= EXP_MAX) begin
         result_d = to_inf ? {sign_q, 8'hFF, 23'b0} : {sign_q, 8'hFE, {23{1'b1}}};
         fflags_d = 5'b00101;
      end else if (exp_r <= EXP_MIN) begin
         result_d = {sign_q, 31'b0};
         fflags_d = 5'b00011;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q  <= ST_IDLE;
         prod_q   <= '0;
         sign_q   <= 1'b0;
         exp_in_q <= '0;
         zero_q   <= 1'b0;
         rm_q     <= '0;
         mant_q   <= '0;
         g_q      <= 1'b0;
         s_q      <= 1'b0;
         exp_q    <= '0;
         result_q <= '0;
         fflags_q <= '0;
      end else if (clk_en_i) begin
         state_q <= state_d;
         if (state_q == ST_IDLE && valid_i) begin
            prod_q   <= product_i[47:0];
            sign_q   <= sign_i;
            exp_in_q <= exp_sum_i;
            zero_q   <= zero_i;
            rm_q     <= rm_i;
         end
         if (state_q == ST_NORM) begin
            mant_q <= mant_d;
            g_q    <= g_d;
            s_q    <= s_d;
            exp_q  <= exp_d;
         end
         if (state_q == ST_ROUND) begin
            result_q <= result_d;
            fflags_q <= fflags_d;
         end
      end
   end

   assign busy_o   = (state_q != ST_IDLE);
   assign valid_o  = (state_q == ST_DONE);
   assign result_o = result_q;
   assign fflags_o = fflags_q;

endmodule

// File: tb/tb_mgt_01_fmul_normalize_round.sv
// tb_mgt_01_fmul_normalize_round
//   Directed vector table plus hand-written handshake, clock-enable and
//   reset sequences for mgt_01_fmul_normalize_round.
module tb_mgt_01_fmul_normalize_round;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        clk_en_i;
   logic [63:0] product_i;
   logic        valid_i;
   logic        sign_i;
   logic [9:0]  exp_sum_i;
   logic        zero_i;
   logic [2:0]  rm_i;
   logic        ready_i;
   logic        busy_o;
   logic        valid_o;
   logic [31:0] result_o;
   logic [4:0]  fflags_o;

   mgt_01_fmul_normalize_round #(.XLEN(32), .EXP_W(10)) dut (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .clk_en_i  (clk_en_i),
      .product_i (product_i),
      .valid_i   (valid_i),
      .sign_i    (sign_i),
      .exp_sum_i (exp_sum_i),
      .zero_i    (zero_i),
      .rm_i      (rm_i),
      .ready_i   (ready_i),
      .busy_o    (busy_o),
      .valid_o   (valid_o),
      .result_o  (result_o),
      .fflags_o  (fflags_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      string       name;
      logic [63:0] prod;
      logic        sign;
      logic [9:0]  exp_sum;
      logic        zero;
      logic [2:0]  rm;
      logic [31:0] res;
      logic [4:0]  flags;
   } vec_t;

   localparam int NVEC = 15;
   vec_t vecs [NVEC];

   int passed = 0;
   int total  = 0;

   function automatic vec_t mk(input string n, input logic [63:0] p, input logic s,
                               input logic [9:0] e, input logic z, input logic [2:0] rm,
                               input logic [31:0] r, input logic [4:0] f);
      vec_t v;
      v.name = n; v.prod = p; v.sign = s; v.exp_sum = e;
      v.zero = z; v.rm = rm; v.res = r; v.flags = f;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
   endtask

   task automatic drive(input vec_t v);
      product_i = v.prod;
      sign_i    = v.sign;
      exp_sum_i = v.exp_sum;
      zero_i    = v.zero;
      rm_i      = v.rm;
   endtask

   // Leaves the bench at the falling edge after the capture edge.
   task automatic start_op(input vec_t v);
      @(negedge clk_i);
      drive(v);
      valid_i = 1'b1;
      @(negedge clk_i);
      valid_i = 1'b0;
   endtask

   // lat counts enabled edges since capture; bounded so a stuck DUT still ends.
   task automatic wait_valid(output int lat);
      lat = 1;
      while (!valid_o && lat < 20) begin
         @(negedge clk_i);
         lat++;
      end
   endtask

   task automatic run_vec(input vec_t v);
      int lat;
      start_op(v);
      wait_valid(lat);
      check({v.name, " latency"}, 32'(lat), 32'd3);
      check({v.name, " result"}, result_o, v.res);
      check({v.name, " fflags"}, 32'(fflags_o), 32'(v.flags));
      ready_i = 1'b1;
      @(negedge clk_i);
      ready_i = 1'b0;
      check({v.name, " valid after ack"}, 32'(valid_o), 32'd0);
      check({v.name, " busy after ack"}, 32'(busy_o), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int lat;
      vecs[0]  = mk("1.5x1.5 RNE",   64'h0000_9000_0000_0000, 1'b0, 10'd127, 1'b0, 3'b000, 32'h4010_0000, 5'b00000);
      vecs[1]  = mk("neg one",       64'h0000_4000_0000_0000, 1'b1, 10'd127, 1'b0, 3'b000, 32'hBF80_0000, 5'b00000);
      vecs[2]  = mk("tie odd RNE",   64'h0000_4000_00C0_0000, 1'b0, 10'd127, 1'b0, 3'b000, 32'h3F80_0002, 5'b00001);
      vecs[3]  = mk("tie odd RTZ",   64'h0000_4000_00C0_0000, 1'b0, 10'd127, 1'b0, 3'b001, 32'h3F80_0001, 5'b00001);
      vecs[4]  = mk("ovf RNE",       64'h0000_8000_0000_0000, 1'b0, 10'd254, 1'b0, 3'b000, 32'h7F80_0000, 5'b00101);
      vecs[5]  = mk("ovf RTZ",       64'h0000_8000_0000_0000, 1'b0, 10'd254, 1'b0, 3'b001, 32'h7F7F_FFFF, 5'b00101);
      vecs[6]  = mk("ovf neg RUP",   64'h0000_8000_0000_0000, 1'b1, 10'd254, 1'b0, 3'b011, 32'hFF7F_FFFF, 5'b00101);
      vecs[7]  = mk("ovf neg RDN",   64'h0000_8000_0000_0000, 1'b1, 10'd254, 1'b0, 3'b010, 32'hFF80_0000, 5'b00101);
      vecs[8]  = mk("underflow",     64'h0000_4000_0000_0000, 1'b1, 10'd0,   1'b0, 3'b000, 32'h8000_0000, 5'b00011);
      vecs[9]  = mk("zero operand",  64'h0000_4000_0000_0000, 1'b1, 10'd0,   1'b1, 3'b000, 32'h8000_0000, 5'b00000);
      vecs[10] = mk("mant carry",    64'h0000_7FFF_FFC0_0000, 1'b0, 10'd127, 1'b0, 3'b000, 32'h4000_0000, 5'b00001);
      vecs[11] = mk("tie even RMM",  64'h0000_4000_0040_0000, 1'b0, 10'd127, 1'b0, 3'b100, 32'h3F80_0001, 5'b00001);
      vecs[12] = mk("tie even RNE",  64'h0000_4000_0040_0000, 1'b0, 10'd127, 1'b0, 3'b000, 32'h3F80_0000, 5'b00001);
      vecs[13] = mk("sticky RUP",    64'h0000_4000_0000_0001, 1'b0, 10'd127, 1'b0, 3'b011, 32'h3F80_0001, 5'b00001);
      vecs[14] = mk("sticky RDN",    64'h0000_4000_0000_0001, 1'b0, 10'd127, 1'b0, 3'b010, 32'h3F80_0000, 5'b00001);

      rst_n_i  = 1'b0;
      clk_en_i = 1'b1;
      valid_i  = 1'b0;
      ready_i  = 1'b0;
      drive(vecs[0]);
      repeat (2) @(negedge clk_i);
      check("reset valid",  32'(valid_o),  32'd0);
      check("reset busy",   32'(busy_o),   32'd0);
      check("reset result", result_o,      32'd0);
      check("reset fflags", 32'(fflags_o), 32'd0);
      rst_n_i = 1'b1;

      for (int i = 0; i < NVEC; i++) run_vec(vecs[i]);

      // Back-pressure: result held while ready_i is low; valid_i ignored.
      start_op(vecs[0]);
      wait_valid(lat);
      check("hold latency", 32'(lat), 32'd3);
      for (int i = 0; i < 5; i++) begin
         if (i == 1) begin
            drive(vecs[1]);
            valid_i = 1'b1;
         end else begin
            valid_i = 1'b0;
         end
         @(negedge clk_i);
         check("hold valid",  32'(valid_o), 32'd1);
         check("hold result", result_o,     32'h4010_0000);
      end
      valid_i = 1'b0;
      ready_i = 1'b1;
      @(negedge clk_i);
      ready_i = 1'b0;
      check("hold valid after ack", 32'(valid_o), 32'd0);
      repeat (3) @(negedge clk_i);
      check("ignored valid not queued", 32'(busy_o), 32'd0);

      // valid_i on the edge that leaves DONE is not captured.
      start_op(vecs[0]);
      wait_valid(lat);
      drive(vecs[1]);
      ready_i = 1'b1;
      valid_i = 1'b1;
      @(negedge clk_i);
      ready_i = 1'b0;
      valid_i = 1'b0;
      check("exit edge valid ignored", 32'(busy_o), 32'd0);
      @(negedge clk_i);
      check("exit edge no result", 32'(valid_o), 32'd0);

      // Clock enable low stalls the pipeline and the DONE handshake.
      start_op(vecs[2]);
      clk_en_i = 1'b0;
      repeat (4) @(negedge clk_i);
      check("stall busy",  32'(busy_o),  32'd1);
      check("stall valid", 32'(valid_o), 32'd0);
      clk_en_i = 1'b1;
      wait_valid(lat);
      check("stall latency", 32'(lat), 32'd3);
      check("stall result",  result_o, 32'h3F80_0002);
      clk_en_i = 1'b0;
      ready_i  = 1'b1;
      repeat (3) @(negedge clk_i);
      check("stall done valid",  32'(valid_o), 32'd1);
      check("stall done result", result_o,     32'h3F80_0002);
      clk_en_i = 1'b1;
      @(negedge clk_i);
      ready_i = 1'b0;
      check("stall ack valid", 32'(valid_o), 32'd0);

      // Reset while in ROUND drops the operation.
      start_op(vecs[0]);
      @(negedge clk_i);
      rst_n_i = 1'b0;
      @(negedge clk_i);
      check("rst round busy",   32'(busy_o),  32'd0);
      check("rst round valid",  32'(valid_o), 32'd0);
      check("rst round result", result_o,     32'd0);
      rst_n_i = 1'b1;
      repeat (5) @(negedge clk_i);
      check("rst no late valid", 32'(valid_o), 32'd0);
      check("rst no late busy",  32'(busy_o),  32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
